alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the next-generation SAP datapath. It adds single-bit shifts, compare, and an iterative shift-add multiplier to the existing add/sub/inc/dec/logic operation set. Operands and results are registered behind a start/busy/done handshake. It sits between the A/B registers and the bus/flags register, driven by the control sequencer.

Parameters:
WIDTH, 16, operand/result width in bits (>=4)
MUL_EN, 1, 1 = op 11 (MUL) implemented; 0 = op 11 treated as undefined

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only when busy=0
op  input  4  operation code, latched on accept
a  input  WIDTH  operand A, latched on accept
b  input  WIDTH  operand B, latched on accept
busy  output  1  high while a multi-cycle MUL is in progress
done  output  1  one-cycle pulse: res/flags just updated
res  output  WIDTH  registered result
flags  output  4  registered {N,C,V,Z}: [0]=Z, [1]=V, [2]=C, [3]=N

Behaviour:
- Reset, async, any state: state=IDLE, res=0, flags=0, busy=0, done=0, iteration counter=0. Reset during MUL aborts it; no done pulse is issued.
- Accept: rising edge with start=1 and busy=0. op, a and b are captured on that edge. Input changes afterwards have no effect.
- start while busy=1 is ignored and not queued. start in the cycle done=1 (IDLE) is accepted, giving back-to-back operation.
- Single-cycle ops (all except MUL with MUL_EN=1): res/flags written on the accept edge. done=1 for exactly the following cycle. busy stays 0.
- MUL: the accept edge enters state MUL, sets busy=1 and counter=WIDTH. One shift-add iteration runs per edge.
  - On the WIDTH-th edge after accept: res and flags are written, busy returns to 0, done=1 for one cycle.
  - Total latency is WIDTH cycles; busy is high for exactly WIDTH cycles.
- FSM: IDLE -> MUL on accept of op 11 with MUL_EN=1; MUL -> IDLE when counter reaches 0. All other ops stay in IDLE.
- Ops, with C and V per op (unsigned C, two's-complement V):
  - 0 ADD: a+b. C=carry out. V=signed overflow.
  - 1 SUB: a-b. C=borrow (a<b unsigned). V=signed overflow.
  - 2 INC: a+1. C/V as ADD.
  - 3 DEC: a-1. C/V as SUB.
  - 4 AND, 5 OR, 6 XOR, 7 NOT(~a): C=0, V=0.
  - 8 SHL: a<<1. C=a[MSB]. V=0.
  - 9 SHR: logical a>>1. C=a[0]. V=0.
  - 10 SAR: arithmetic a>>>1. C=a[0]. V=0.
  - 11 MUL: unsigned a*b, res = low WIDTH bits. C=1 iff the high WIDTH bits are nonzero. V=0.
  - 12 CMP: computes a-b for flags only (Z,N,C,V as SUB); res keeps its previous value.
  - 13-15, and 11 with MUL_EN=0: res=0, Z=1, N=C=V=0. Single-cycle, done pulses.
- Z = (written result == 0); N = written result MSB. For CMP, Z and N come from the difference, not from res.
- Flags and res hold their values between operations; only done pulses.

Test Plan:
- WIDTH=16, ADD a=0x7FFF b=0x0001 -> next cycle res=0x8000, flags N=1 C=0 V=1 Z=0, done high exactly 1 cycle, busy never high.
- SUB a=0x0005 b=0x0007 -> res=0xFFFE, N=1 C=1 V=0 Z=0. Then CMP a=0x0005 b=0x0005 -> Z=1 C=0, res still 0xFFFE.
- MUL a=0x0123 b=0x0100 -> busy high 16 cycles, done on the 16th edge after accept, res=0x2300, C=1. A start pulse with ADD during busy is ignored (no extra done).
- SAR a=0x8001 -> res=0xC000, C=1, N=1. SHR a=0x8001 -> res=0x4000, C=1, N=0. SHL a=0x8000 -> res=0x0000, Z=1, C=1.
- Assert rst during MUL iteration 5 -> busy=0, res=0, flags=0 immediately, no done pulse. A new ADD 2+3 afterwards gives res=5.
- MUL_EN=0, op=11 a=3 b=4 -> single-cycle, res=0, Z=1, done after 1 cycle. Back-to-back starts on consecutive cycles produce consecutive done pulses.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the SAP datapath.
// Single-cycle add/sub/inc/dec/logic/shift/compare ops, plus an iterative
// shift-add multiplier (op 11) behind a start/busy/done handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready; start is accepted, single-cycle ops complete here
// S_MUL  | shift-add multiply in progress, one iteration per edge
module alu_mc #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_SAR = 4'd10;
    localparam logic [3:0] OP_MUL = 4'd11;
    localparam logic [3:0] OP_CMP = 4'd12;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;

    logic accept, is_mul, mul_last;

    assign busy     = (state == S_MUL);
    assign accept   = start && (state == S_IDLE);
    assign is_mul   = MUL_EN && (op == OP_MUL);
    assign mul_last = (state == S_MUL) && (cnt == CNT_LAST);

    // Single-cycle datapath: arithmetic with one extra bit to expose carry/borrow
    logic [WIDTH:0] add_ab, sub_ab, inc_a, dec_a;
    assign add_ab = {1'b0, a} + {1'b0, b};
    assign sub_ab = {1'b0, a} - {1'b0, b};
    assign inc_a  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_a  = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_wr_res;
    logic [3:0]       sc_flags;

    // Result and C/V for the op on the inputs; CMP only updates flags
    always_comb begin
        sc_res    = '0;
        sc_c      = 1'b0;
        sc_v      = 1'b0;
        sc_wr_res = 1'b1;
        case (op)
            OP_ADD: begin
                sc_res = add_ab[MSB:0];
                sc_c   = add_ab[WIDTH];
                sc_v   = (a[MSB] == b[MSB]) && (add_ab[MSB] != a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                sc_res    = sub_ab[MSB:0];
                sc_c      = sub_ab[WIDTH];
                sc_v      = (a[MSB] != b[MSB]) && (sub_ab[MSB] != a[MSB]);
                sc_wr_res = (op == OP_SUB);
            end
            OP_INC: begin
                sc_res = inc_a[MSB:0];
                sc_c   = inc_a[WIDTH];
                sc_v   = !a[MSB] && inc_a[MSB];
            end
            OP_DEC: begin
                sc_res = dec_a[MSB:0];
                sc_c   = dec_a[WIDTH];
                sc_v   = a[MSB] && !dec_a[MSB];
            end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_NOT: sc_res = ~a;
            OP_SHL: begin
                sc_res = {a[MSB-1:0], 1'b0};
                sc_c   = a[MSB];
            end
            OP_SHR: begin
                sc_res = {1'b0, a[MSB:1]};
                sc_c   = a[0];
            end
            OP_SAR: begin
                sc_res = {a[MSB], a[MSB:1]};
                sc_c   = a[0];
            end
            // 11 (when not handled as MUL) and 13-15 yield zero with Z set
            default: begin
                sc_res = '0;
            end
        endcase
        sc_flags = {sc_res[MSB], sc_c, sc_v, (sc_res == '0)};
    end

    // One shift-add step: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole product right
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   mul_hi, mul_lo;

    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_step = {mul_sum, prod[MSB:1]};
    assign mul_hi    = prod_step[2*WIDTH-1:WIDTH];
    assign mul_lo    = prod_step[MSB:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
            S_MUL:   if (mul_last)         state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: operand capture, multiply iterations, result/flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            mcand <= '0;
            prod  <= '0;
            res   <= '0;
            flags <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (is_mul) begin
                    cnt   <= CNT_INIT;
                    mcand <= a;
                    prod  <= {{WIDTH{1'b0}}, b};
                end else begin
                    if (sc_wr_res) res <= sc_res;
                    flags <= sc_flags;
                    done  <= 1'b1;
                end
            end else if (state == S_MUL) begin
                prod <= prod_step;
                cnt  <= cnt - CNT_LAST;
                if (mul_last) begin
                    res   <= mul_lo;
                    flags <= {mul_lo[MSB], (mul_hi != '0), 1'b0, (mul_lo == '0)};
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: directed vector table for single-cycle ops,
// hand-written sequences for multiply, abort-by-reset and MUL_EN=0.
module tb_alu_mc;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         busy, done, busy0, done0;
    logic [W-1:0] res, res0;
    logic [3:0]   flags, flags0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .res(res), .flags(flags)
    );

    alu_mc #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy0), .done(done0), .res(res0), .flags(flags0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic [3:0]   exp_flags;   // {N,C,V,Z}
    } vec_t;

    vec_t vecs[16];
    int   busy_cnt, done_cnt;
    logic done_at_end;

    initial begin
        vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 4'b1010}; // ADD signed overflow
        vecs[1]  = '{4'd1,  16'h0005, 16'h0007, 16'hFFFE, 4'b1100}; // SUB borrow
        vecs[2]  = '{4'd12, 16'h0005, 16'h0005, 16'hFFFE, 4'b0001}; // CMP equal, res held
        vecs[3]  = '{4'd10, 16'h8001, 16'h0000, 16'hC000, 4'b1100}; // SAR
        vecs[4]  = '{4'd9,  16'h8001, 16'h0000, 16'h4000, 4'b0100}; // SHR
        vecs[5]  = '{4'd8,  16'h8000, 16'h0000, 16'h0000, 4'b0101}; // SHL out to zero
        vecs[6]  = '{4'd2,  16'hFFFF, 16'h0000, 16'h0000, 4'b0101}; // INC wrap
        vecs[7]  = '{4'd3,  16'h8000, 16'h0000, 16'h7FFF, 4'b0010}; // DEC signed overflow
        vecs[8]  = '{4'd4,  16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000}; // AND
        vecs[9]  = '{4'd5,  16'hF000, 16'h000F, 16'hF00F, 4'b1000}; // OR
        vecs[10] = '{4'd6,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b0001}; // XOR to zero
        vecs[11] = '{4'd7,  16'h00FF, 16'h0000, 16'hFF00, 4'b1000}; // NOT
        vecs[12] = '{4'd13, 16'h0001, 16'h0002, 16'h0000, 4'b0001}; // undefined op
        vecs[13] = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 4'b0101}; // ADD carry, no V
        vecs[14] = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 4'b0010}; // SUB signed overflow
        vecs[15] = '{4'd12, 16'h0003, 16'h0005, 16'h7FFF, 4'b1100}; // CMP less, res held

        // Reset
        #2 rst = 1'b1;
        #1;
        check("rst_res",   res,   '0);
        check("rst_flags", flags, '0);
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single-cycle vector table
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = 1'b1; op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            @(negedge clk);
            start = 1'b0; a = 16'h1234; b = 16'h5678;
            check($sformatf("v%0d_done", i),  done,  1'b1);
            check($sformatf("v%0d_busy", i),  busy,  1'b0);
            check($sformatf("v%0d_res", i),   res,   vecs[i].exp_res);
            check($sformatf("v%0d_flags", i), flags, vecs[i].exp_flags);
            @(negedge clk);
            check($sformatf("v%0d_done_off", i), done, 1'b0);
            check($sformatf("v%0d_hold", i),     res,  vecs[i].exp_res);
        end

        // MUL with an ignored start during busy
        @(negedge clk);
        start = 1'b1; op = 4'd11; a = 16'h0123; b = 16'h0100;
        @(posedge clk);
        busy_cnt = 0; done_cnt = 0; done_at_end = 1'b0;
        for (int i = 0; i <= W; i++) begin
            @(negedge clk);
            start = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
            if (i == 3) begin start = 1'b1; op = 4'd0; a = 16'h0001; b = 16'h0001; end
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (i == W) done_at_end = done;
        end
        check("mul_busy_cycles", busy_cnt, W);
        check("mul_done_count",  done_cnt, 1);
        check("mul_done_edge",   done_at_end, 1'b1);
        check("mul_res",         res,   16'h2300);
        check("mul_flags",       flags, 4'b0100);
        @(negedge clk);
        check("mul_no_extra_done", done, 1'b0);
        check("mul_no_queue_busy", busy, 1'b0);
        check("mul_res_hold",      res,  16'h2300);

        // Reset during MUL iteration 5
        @(negedge clk);
        start = 1'b1; op = 4'd11; a = 16'h0123; b = 16'h0100;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("abort_busy_before", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("abort_busy",  busy,  1'b0);
        check("abort_res",   res,   '0);
        check("abort_flags", flags, '0);
        check("abort_done",  done,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        check("abort_no_done", done_cnt, 0);
        @(negedge clk);
        start = 1'b1; op = 4'd0; a = 16'd2; b = 16'd3;
        @(negedge clk);
        start = 1'b0;
        check("post_abort_done",  done,  1'b1);
        check("post_abort_res",   res,   16'd5);
        check("post_abort_flags", flags, 4'b0000);

        // MUL_EN=0: op 11 single-cycle zero; back-to-back accepts
        @(negedge clk);
        start = 1'b1; op = 4'd0; a = 16'd1; b = 16'd1;
        @(negedge clk);
        check("b2b0_done", done0, 1'b1);
        check("b2b0_res",  res0,  16'd2);
        op = 4'd1; a = 16'd9; b = 16'd4;
        @(negedge clk);
        check("b2b1_done", done0, 1'b1);
        check("b2b1_res",  res0,  16'd5);
        op = 4'd11; a = 16'd3; b = 16'd4;
        @(negedge clk);
        start = 1'b0;
        check("nomul_done",  done0,  1'b1);
        check("nomul_busy",  busy0,  1'b0);
        check("nomul_res",   res0,   16'd0);
        check("nomul_flags", flags0, 4'b0001);
        @(negedge clk);
        check("nomul_done_off", done0, 1'b0);
        check("nomul_busy_off", busy0, 1'b0);

        // Let the MUL_EN=1 instance finish the multiply it accepted
        repeat (W + 2) @(negedge clk);
        check("final_mul_res", res, 16'd12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
